// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: one-at-a-time load/store controller between the memory stage
// and a req/gnt/rvalid data bus; aligns lanes, extends loads, flags errors.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               core request (valid/ready), addr, op, wr, wdata
//   resp_*              core response (valid/ready), rdata, err
//   mem_req/gnt/we      bus request held until grant, write enable
//   mem_addr/wdata/wstrb aligned address, lane-shifted data, byte enables
//   mem_rvalid/rdata    bus completion and full aligned read word
module lsu_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [2:0]              req_op,
    input  logic                    req_wr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2:0]              op_q, op_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [7:0]              cnt_q, cnt_d;

    logic [OFFW-1:0]         off;
    logic [DATA_WIDTH-1:0]   rsh;

    // 011/110 are 64-bit only; 111 is never legal
    function automatic logic illegal_op(input logic [2:0] op);
        return (op == 3'b111) ||
               ((DATA_WIDTH == 32) && (op == 3'b011 || op == 3'b110));
    endfunction

    function automatic logic misaligned(input logic [1:0] sz,
                                        input logic [2:0] a);
        logic m;
        unique case (sz)
            2'd0:    m = 1'b0;
            2'd1:    m = a[0];
            2'd2:    m = |a[1:0];
            default: m = |a[2:0];
        endcase
        return m;
    endfunction

    function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++)
            m[i] = (i < (1 << sz));
        return m;
    endfunction

    // op[2] selects zero extension; size comes from op[1:0]
    function automatic logic [DATA_WIDTH-1:0] load_ext(
        input logic [DATA_WIDTH-1:0] r, input logic [2:0] op);
        int bits;
        logic s;
        logic [DATA_WIDTH-1:0] o;
        bits = 8 << op[1:0];
        s = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (i == bits - 1) s = r[i] & ~op[2];
        for (int i = 0; i < DATA_WIDTH; i++)
            o[i] = (i < bits) ? r[i] : s;
        return o;
    endfunction

    assign off = addr_q[OFFW-1:0];
    assign rsh = mem_rdata >> {off, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            op_q    <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    op_d    = req_op;
                    wr_d    = req_wr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (illegal_op(req_op) ||
                        misaligned(req_op[1:0], req_addr[2:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = wr_q ? '0 : load_ext(rsh, op_q);
                end else if (cnt_q == TO_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign mem_req    = (state_q == ISSUE);
    assign mem_we     = mem_req & wr_q;
    assign mem_addr   = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    assign mem_wstrb  = mem_we ? (size_mask(op_q[1:0]) << off) : '0;
    assign mem_wdata  = wr_q ? (wdata_q << {off, 3'b000}) : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl, 32- and 64-bit builds.
// Stimulus selects one instance at a time through a shared driver.
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        d_req_valid, d_req_wr, d_resp_ready, d_gnt, d_rvalid;
    logic [31:0] d_addr;
    logic [2:0]  d_op;
    logic [63:0] d_wdata, d_rdata;

    logic        a_req_valid, a_resp_ready, a_gnt, a_rvalid;
    logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_req, a_mem_we;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_wstrb;

    logic        b_req_valid, b_resp_ready, b_gnt, b_rvalid;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_req, b_mem_we;
    logic [63:0] b_resp_rdata, b_mem_wdata;
    logic [31:0] b_mem_addr;
    logic [7:0]  b_mem_wstrb;

    assign a_req_valid  = ~sel & d_req_valid;
    assign a_resp_ready = ~sel & d_resp_ready;
    assign a_gnt        = ~sel & d_gnt;
    assign a_rvalid     = ~sel & d_rvalid;
    assign b_req_valid  = sel & d_req_valid;
    assign b_resp_ready = sel & d_resp_ready;
    assign b_gnt        = sel & d_gnt;
    assign b_rvalid     = sel & d_rvalid;

    lsu_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(15)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_addr(d_addr), .req_op(d_op), .req_wr(d_req_wr),
        .req_wdata(d_wdata[31:0]),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .mem_req(a_mem_req), .mem_gnt(a_gnt), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_wstrb(a_mem_wstrb), .mem_rvalid(a_rvalid),
        .mem_rdata(d_rdata[31:0])
    );

    lsu_mem_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(15)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(d_addr), .req_op(d_op), .req_wr(d_req_wr),
        .req_wdata(d_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_req(b_mem_req), .mem_gnt(b_gnt), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_wstrb(b_mem_wstrb), .mem_rvalid(b_rvalid),
        .mem_rdata(d_rdata)
    );

    logic        o_req_ready, o_resp_valid, o_err, o_mem_req, o_we;
    logic [63:0] o_rdata, o_mwdata;
    logic [31:0] o_maddr;
    logic [7:0]  o_wstrb;

    assign o_req_ready  = sel ? b_req_ready  : a_req_ready;
    assign o_resp_valid = sel ? b_resp_valid : a_resp_valid;
    assign o_err        = sel ? b_resp_err   : a_resp_err;
    assign o_mem_req    = sel ? b_mem_req    : a_mem_req;
    assign o_we         = sel ? b_mem_we     : a_mem_we;
    assign o_rdata      = sel ? b_resp_rdata : {32'h0, a_resp_rdata};
    assign o_mwdata     = sel ? b_mem_wdata  : {32'h0, a_mem_wdata};
    assign o_maddr      = sel ? b_mem_addr   : a_mem_addr;
    assign o_wstrb      = sel ? b_mem_wstrb  : {4'h0, a_mem_wstrb};

    int total = 0;
    int bad = 0;
    logic [64:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] addr, input logic [2:0] op,
                        input logic wr, input logic [63:0] wdata);
        @(negedge clk);
        chk("req_ready", 64'(o_req_ready), 64'd1);
        d_req_valid = 1'b1;
        d_addr      = addr;
        d_op        = op;
        d_req_wr    = wr;
        d_wdata     = wdata;
        @(negedge clk);
        d_req_valid = 1'b0;
        chk("rdy_low", 64'(o_req_ready), 64'd0);
    endtask

    // rv_dly < 0 withholds the completion entirely
    task automatic bus(input int gnt_dly, input int rv_dly,
                       input logic [63:0] rdata, input logic [7:0] strb,
                       input logic [31:0] maddr, input logic [63:0] mwdata,
                       input logic we);
        for (int i = 0; i <= gnt_dly; i++) begin
            chk("mem_req", 64'(o_mem_req), 64'd1);
            chk("wstrb", 64'(o_wstrb), 64'(strb));
            chk("maddr", 64'(o_maddr), 64'(maddr));
            chk("we", 64'(o_we), 64'(we));
            if (we) chk("mwdata", o_mwdata, mwdata);
            chk("rdy_issue", 64'(o_req_ready), 64'd0);
            d_rvalid = (i < gnt_dly);
            d_rdata  = 64'hDEAD_0000_DEAD_0000;
            d_gnt    = (i == gnt_dly);
            @(negedge clk);
        end
        d_gnt    = 1'b0;
        d_rvalid = 1'b0;
        chk("req_drop", 64'(o_mem_req), 64'd0);
        if (rv_dly >= 0) begin
            repeat (rv_dly) @(negedge clk);
            d_rvalid = 1'b1;
            d_rdata  = rdata;
            @(negedge clk);
            d_rvalid = 1'b0;
        end
    endtask

    task automatic get_resp(input int bound, input int rdy_dly,
                            output int n);
        logic [64:0] e;
        n = 0;
        while (!o_resp_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!o_resp_valid) begin
            chk("resp_tmo", 64'd0, 64'd1);
        end else begin
            if (sb.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
                e = '0;
            end else begin
                e = sb.pop_front();
            end
            for (int i = 0; i < rdy_dly; i++) begin
                chk("hold_v", 64'(o_resp_valid), 64'd1);
                chk("hold_d", o_rdata, e[63:0]);
                chk("hold_rdy", 64'(o_req_ready), 64'd0);
                chk("hold_req", 64'(o_mem_req), 64'd0);
                @(negedge clk);
            end
            chk("rdata", o_rdata, e[63:0]);
            chk("err", 64'(o_err), 64'(e[64]));
            d_resp_ready = 1'b1;
            @(negedge clk);
            d_resp_ready = 1'b0;
            chk("resp_once", 64'(o_resp_valid), 64'd0);
            chk("back_idle", 64'(o_req_ready), 64'd1);
        end
    endtask

    task automatic load(input logic [31:0] addr, input logic [2:0] op,
                        input logic [63:0] rdata, input logic [31:0] maddr,
                        input logic [63:0] exp);
        int n;
        sb.push_back({1'b0, exp});
        send(addr, op, 1'b0, 64'h0);
        bus(0, 1, rdata, 8'h00, maddr, 64'h0, 1'b0);
        get_resp(40, 0, n);
    endtask

    task automatic store(input logic [31:0] addr, input logic [2:0] op,
                         input logic [63:0] wdata, input logic [7:0] strb,
                         input logic [31:0] maddr, input logic [63:0] mw);
        int n;
        sb.push_back({1'b0, 64'h0});
        send(addr, op, 1'b1, wdata);
        bus(1, 0, 64'h0, strb, maddr, mw, 1'b1);
        get_resp(40, 1, n);
    endtask

    task automatic bad_req(input logic [31:0] addr, input logic [2:0] op,
                           input logic wr);
        int n;
        sb.push_back({1'b1, 64'h0});
        send(addr, op, wr, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("err_nobus", 64'(o_mem_req), 64'd0);
        get_resp(40, 0, n);
        chk("err_lat", 64'(n), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        sel = 1'b0;
        d_req_valid = 0; d_req_wr = 0; d_resp_ready = 0;
        d_gnt = 0; d_rvalid = 0;
        d_addr = '0; d_op = '0; d_wdata = '0; d_rdata = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_ready", 64'(o_req_ready), 64'd1);
            chk("rst_rvalid", 64'(o_resp_valid), 64'd0);
            chk("rst_req", 64'(o_mem_req), 64'd0);
            chk("rst_strb", 64'(o_wstrb), 64'd0);
            chk("rst_rdata", o_rdata, 64'd0);
            chk("rst_err", 64'(o_err), 64'd0);
        end
        sel = 1'b0;
        rst = 1'b0;

        // lb with full latency measurement
        sb.push_back({1'b0, 64'h0000_0000_FFFF_FF80});
        send(32'h8000_0003, 3'b000, 1'b0, 64'h0);
        bus(0, 0, 64'h80AB_CDEF, 8'h0, 32'h8000_0000, 64'h0, 1'b0);
        get_resp(40, 0, n);
        chk("lat3", 64'(n), 64'd0);

        // sh with slow grant and slow response accept
        sb.push_back({1'b0, 64'h0});
        send(32'h8000_0002, 3'b001, 1'b1, 64'h1234_5678);
        bus(4, 1, 64'h0, 8'hC, 32'h8000_0000, 64'h5678_0000, 1'b1);
        get_resp(40, 3, n);

        bad_req(32'h8000_0001, 3'b010, 1'b0);

        // lhu timeout, then a stray completion
        sb.push_back({1'b1, 64'h0});
        send(32'h8000_0002, 3'b101, 1'b0, 64'h0);
        bus(0, -1, 64'h0, 8'h0, 32'h8000_0000, 64'h0, 1'b0);
        get_resp(40, 0, n);
        chk("tmo_cyc", 64'(n), 64'd15);
        d_rvalid = 1'b1;
        d_rdata  = 64'h1234_5678;
        @(negedge clk);
        d_rvalid = 1'b0;
        chk("late_rv", 64'(o_resp_valid), 64'd0);
        chk("late_rdy", 64'(o_req_ready), 64'd1);

        load(32'h8000_0002, 3'b001, 64'h8001_0000, 32'h8000_0000,
             64'hFFFF_8001);
        load(32'h8000_0001, 3'b100, 64'h0000_A500, 32'h8000_0000,
             64'h0000_00A5);
        load(32'h8000_0004, 3'b010, 64'hDEAD_BEEF, 32'h8000_0004,
             64'hDEAD_BEEF);
        load(32'h8000_0000, 3'b101, 64'h1234_F00D, 32'h8000_0000,
             64'h0000_F00D);
        store(32'h8000_0003, 3'b000, 64'hAB, 8'h8, 32'h8000_0000,
              64'hAB00_0000);
        bad_req(32'h8000_0000, 3'b011, 1'b0);
        bad_req(32'h8000_0000, 3'b111, 1'b1);
        bad_req(32'h8000_0002, 3'b110, 1'b0);

        // reset during WAIT, completion afterwards must be dropped
        send(32'h8000_0008, 3'b010, 1'b0, 64'h0);
        d_gnt = 1'b1;
        @(negedge clk);
        d_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        d_rvalid = 1'b1;
        d_rdata  = 64'h5555_AAAA;
        chk("rstw_rdy", 64'(o_req_ready), 64'd1);
        chk("rstw_req", 64'(o_mem_req), 64'd0);
        chk("rstw_rv", 64'(o_resp_valid), 64'd0);
        @(negedge clk);
        d_rvalid = 1'b0;
        chk("rstw_rv2", 64'(o_resp_valid), 64'd0);
        chk("rstw_rdy2", 64'(o_req_ready), 64'd1);

        // reset during ISSUE drops the bus request
        send(32'h8000_0010, 3'b010, 1'b0, 64'h0);
        chk("rsti_req", 64'(o_mem_req), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rsti_drop", 64'(o_mem_req), 64'd0);
        chk("rsti_rdy", 64'(o_req_ready), 64'd1);

        sel = 1'b1;
        load(32'h0000_0008, 3'b011, 64'h0123_4567_89AB_CDEF,
             32'h0000_0008, 64'h0123_4567_89AB_CDEF);
        load(32'h0000_000C, 3'b010, 64'h89AB_CDEF_0123_4567,
             32'h0000_0008, 64'hFFFF_FFFF_89AB_CDEF);
        load(32'h0000_000C, 3'b110, 64'h89AB_CDEF_0123_4567,
             32'h0000_0008, 64'h0000_0000_89AB_CDEF);
        load(32'h0000_0007, 3'b000, 64'h7F00_0000_0000_0000,
             32'h0000_0000, 64'h0000_0000_0000_007F);
        store(32'h0000_000C, 3'b010, 64'hCAFE_F00D, 8'hF0,
              32'h0000_0008, 64'hCAFE_F00D_0000_0000);
        store(32'h0000_0010, 3'b011, 64'h1122_3344_5566_7788, 8'hFF,
              32'h0000_0010, 64'h1122_3344_5566_7788);
        bad_req(32'h0000_0004, 3'b011, 1'b0);
        bad_req(32'h0000_0000, 3'b111, 1'b0);

        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
